// File: rtl/br_fwd_pkg.sv
// -----------------------------------------------------------------------------
// br_fwd_pkg
// Shared types for the branch operand forwarding unit.
//   fwd_sel_e     : per-source operand select (ID / EX alu / MEM alu / MEM load)
//   stall_state_e : stall-reason state held by br_fwd_unit
// -----------------------------------------------------------------------------
package br_fwd_pkg;

    typedef enum logic [1:0] {
        FWD_ID      = 2'b00,
        FWD_EX_ALU  = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_STALL_EXLD  = 2'b01,
        ST_STALL_MEMLD = 2'b10
    } stall_state_e;

endpackage : br_fwd_pkg

// File: rtl/br_fwd_sel.sv
// -----------------------------------------------------------------------------
// br_fwd_sel
// Forwarding select for a single branch source operand: detects EX/MEM
// producer matches, applies EX-over-MEM priority and muxes the operand.
// Purely combinational.
//   i_rs_addr / i_rs_data        : register-file address and read data
//   i_ex_*                       : EX stage destination, write enable, load flag, alu result
//   i_mem_*                      : MEM stage destination, write enable, load flag, alu result, load data
//   o_fwd_sel                    : chosen source (fwd_sel_e)
//   o_rs_data                    : forwarded operand
//   o_ex_ld_hit                  : operand is produced by a load still in EX
// -----------------------------------------------------------------------------
module br_fwd_sel
    import br_fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [XLEN-1:0]   i_rs_data,
    input  logic [REG_AW-1:0] i_ex_rd_addr,
    input  logic              i_ex_rd_wren,
    input  logic              i_ex_is_ld,
    input  logic [XLEN-1:0]   i_ex_alu_data,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic              i_mem_rd_wren,
    input  logic              i_mem_is_ld,
    input  logic [XLEN-1:0]   i_mem_alu_data,
    input  logic [XLEN-1:0]   i_mem_ld_data,
    output fwd_sel_e          o_fwd_sel,
    output logic [XLEN-1:0]   o_rs_data,
    output logic              o_ex_ld_hit
);

    logic w_src_nz;
    logic w_ex_hit;
    logic w_mem_hit;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign w_src_nz  = (i_rs_addr != '0);
    assign w_ex_hit  = i_ex_rd_wren  && (i_ex_rd_addr  == i_rs_addr) && w_src_nz;
    assign w_mem_hit = i_mem_rd_wren && (i_mem_rd_addr == i_rs_addr) && w_src_nz;

    assign o_ex_ld_hit = w_ex_hit && i_ex_is_ld;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_fwd_sel = FWD_ID;
        // EX holds the youngest producer. On an EX load hit the operand is
        // not yet available and the unit stalls, so the data is don't-care.
        if (w_ex_hit) begin
            o_fwd_sel = FWD_EX_ALU;
        end else if (w_mem_hit) begin
            o_fwd_sel = i_mem_is_ld ? FWD_MEM_LD : FWD_MEM_ALU;
        end
    end

    always_comb begin
        o_rs_data = i_rs_data;
        case (o_fwd_sel)
            FWD_EX_ALU:  o_rs_data = i_ex_alu_data;
            FWD_MEM_ALU: o_rs_data = i_mem_alu_data;
            FWD_MEM_LD:  o_rs_data = i_mem_ld_data;
            default:     o_rs_data = i_rs_data;
        endcase
    end

endmodule : br_fwd_sel

// File: rtl/br_fwd_unit.sv
// -----------------------------------------------------------------------------
// br_fwd_unit
// Branch operand forwarding and load-use stall control for the ID stage.
// One br_fwd_sel per source does the matching and muxing; this level derives
// stall_o, tracks the stall reason, counts consecutive stalled cycles and
// raises a sticky timeout flag when the count reaches MAX_STALL.
//   clk_i, rst_i (sync, active-high)
//   ID_is_br_i, ID_rs_addr_i, ID_rs_data_i     : branch in ID and its sources
//   EX_* / MEM_*                               : producer info per stage
//   rs_data_o, fwd_sel_o                       : forwarded operands and selects
//   stall_o, stall_timeout_o                   : stall request, sticky timeout
//   perf_stall_cnt_o                           : total stalled cycles (only with BR_FWD_PERF_EN)
// Optional feature macro: BR_FWD_PERF_EN
// -----------------------------------------------------------------------------
module br_fwd_unit
    import br_fwd_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_SRC   = 2,
    parameter int REG_AW    = 5,
    parameter int MAX_STALL = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           ID_is_br_i,
    input  logic [NUM_SRC-1:0][REG_AW-1:0] ID_rs_addr_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]   ID_rs_data_i,
    input  logic [REG_AW-1:0]              EX_rd_addr_i,
    input  logic                           EX_rd_wren_i,
    input  logic                           EX_is_ld_i,
    input  logic [XLEN-1:0]                EX_alu_data_i,
    input  logic [REG_AW-1:0]              MEM_rd_addr_i,
    input  logic                           MEM_rd_wren_i,
    input  logic                           MEM_is_ld_i,
    input  logic [XLEN-1:0]                MEM_alu_data_i,
    input  logic [XLEN-1:0]                MEM_ld_data_i,
    input  logic                           MEM_ld_vld_i,
    output logic [NUM_SRC-1:0][XLEN-1:0]   rs_data_o,
    output logic [NUM_SRC-1:0][1:0]        fwd_sel_o,
    output logic                           stall_o,
`ifdef BR_FWD_PERF_EN
    output logic [31:0]                    perf_stall_cnt_o,
`endif
    output logic                           stall_timeout_o
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);

    fwd_sel_e           w_sel [NUM_SRC];
    logic [NUM_SRC-1:0] w_ex_ld_hit;
    logic [NUM_SRC-1:0] w_mem_ld_sel;
    logic               w_stall_exld;
    logic               w_stall_memld;
    stall_state_e       w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    stall_state_e       r_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_timeout;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        br_fwd_sel #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
        ) u_sel (
            .i_rs_addr      (ID_rs_addr_i[g]),
            .i_rs_data      (ID_rs_data_i[g]),
            .i_ex_rd_addr   (EX_rd_addr_i),
            .i_ex_rd_wren   (EX_rd_wren_i),
            .i_ex_is_ld     (EX_is_ld_i),
            .i_ex_alu_data  (EX_alu_data_i),
            .i_mem_rd_addr  (MEM_rd_addr_i),
            .i_mem_rd_wren  (MEM_rd_wren_i),
            .i_mem_is_ld    (MEM_is_ld_i),
            .i_mem_alu_data (MEM_alu_data_i),
            .i_mem_ld_data  (MEM_ld_data_i),
            .o_fwd_sel      (w_sel[g]),
            .o_rs_data      (rs_data_o[g]),
            .o_ex_ld_hit    (w_ex_ld_hit[g])
        );

        assign fwd_sel_o[g]    = w_sel[g];
        assign w_mem_ld_sel[g] = (w_sel[g] == FWD_MEM_LD);
    end

    // Stall is decided in the current cycle; the moment MEM_ld_vld_i rises the
    // MEMLD term drops and the load data goes straight through the mux.
    assign w_stall_exld  = ID_is_br_i && (|w_ex_ld_hit);
    assign w_stall_memld = ID_is_br_i && (|w_mem_ld_sel) && !MEM_ld_vld_i;
    assign stall_o       = w_stall_exld || w_stall_memld;

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_stall_exld) begin
            w_state_nxt = ST_STALL_EXLD;
        end else if (w_stall_memld) begin
            w_state_nxt = ST_STALL_MEMLD;
        end
    end

    // Saturating count of consecutive stalled cycles; any free cycle clears it.
    always_comb begin
        w_cnt_nxt = '0;
        if (stall_o) begin
            w_cnt_nxt = (r_stall_cnt == CNT_W'(MAX_STALL)) ? r_stall_cnt
                                                            : r_stall_cnt + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_cnt_nxt;
            // Flag rises on the edge where the count lands on MAX_STALL.
            if (w_cnt_nxt == CNT_W'(MAX_STALL)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall_timeout_o = r_timeout;

`ifdef BR_FWD_PERF_EN
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_stall_cnt <= '0;
        end else if (stall_o) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf_stall_cnt;
`endif

endmodule : br_fwd_unit

// File: tb/tb_br_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_br_fwd_unit
// Directed bench for br_fwd_unit with MAX_STALL=4 and default widths.
// -----------------------------------------------------------------------------
module tb_br_fwd_unit;
    import br_fwd_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;

    logic                           clk_i = 1'b0;
    logic                           rst_i;
    logic                           ID_is_br_i;
    logic [NUM_SRC-1:0][REG_AW-1:0] ID_rs_addr_i;
    logic [NUM_SRC-1:0][XLEN-1:0]   ID_rs_data_i;
    logic [REG_AW-1:0]              EX_rd_addr_i;
    logic                           EX_rd_wren_i;
    logic                           EX_is_ld_i;
    logic [XLEN-1:0]                EX_alu_data_i;
    logic [REG_AW-1:0]              MEM_rd_addr_i;
    logic                           MEM_rd_wren_i;
    logic                           MEM_is_ld_i;
    logic [XLEN-1:0]                MEM_alu_data_i;
    logic [XLEN-1:0]                MEM_ld_data_i;
    logic                           MEM_ld_vld_i;
    logic [NUM_SRC-1:0][XLEN-1:0]   rs_data_o;
    logic [NUM_SRC-1:0][1:0]        fwd_sel_o;
    logic                           stall_o;
    logic                           stall_timeout_o;
`ifdef BR_FWD_PERF_EN
    logic [31:0]                    perf_stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ID0  = 32'hA000_0000;
    localparam logic [31:0] ID1  = 32'hB111_1111;
    localparam logic [31:0] EXA  = 32'h1111_0005;
    localparam logic [31:0] MEMA = 32'h2222_0005;
    localparam logic [31:0] LDD  = 32'hDEAD_BEEF;

    always #5 clk_i = ~clk_i;

    br_fwd_unit #(
        .XLEN      (XLEN),
        .NUM_SRC   (NUM_SRC),
        .REG_AW    (REG_AW),
        .MAX_STALL (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ID_is_br_i      (ID_is_br_i),
        .ID_rs_addr_i    (ID_rs_addr_i),
        .ID_rs_data_i    (ID_rs_data_i),
        .EX_rd_addr_i    (EX_rd_addr_i),
        .EX_rd_wren_i    (EX_rd_wren_i),
        .EX_is_ld_i      (EX_is_ld_i),
        .EX_alu_data_i   (EX_alu_data_i),
        .MEM_rd_addr_i   (MEM_rd_addr_i),
        .MEM_rd_wren_i   (MEM_rd_wren_i),
        .MEM_is_ld_i     (MEM_is_ld_i),
        .MEM_alu_data_i  (MEM_alu_data_i),
        .MEM_ld_data_i   (MEM_ld_data_i),
        .MEM_ld_vld_i    (MEM_ld_vld_i),
        .rs_data_o       (rs_data_o),
        .fwd_sel_o       (fwd_sel_o),
        .stall_o         (stall_o),
`ifdef BR_FWD_PERF_EN
        .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
        .stall_timeout_o (stall_timeout_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        ID_is_br_i      = 1'b0;
        ID_rs_addr_i[0] = '0;
        ID_rs_addr_i[1] = '0;
        ID_rs_data_i[0] = ID0;
        ID_rs_data_i[1] = ID1;
        EX_rd_addr_i    = '0;
        EX_rd_wren_i    = 1'b0;
        EX_is_ld_i      = 1'b0;
        EX_alu_data_i   = EXA;
        MEM_rd_addr_i   = '0;
        MEM_rd_wren_i   = 1'b0;
        MEM_is_ld_i     = 1'b0;
        MEM_alu_data_i  = MEMA;
        MEM_ld_data_i   = LDD;
        MEM_ld_vld_i    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        tick();
        check("rst_state", dut.r_state, ST_IDLE);
        check("rst_timeout", stall_timeout_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        rst_i = 1'b0;
        tick();

        // EX non-load producer of rs1=5.
        ID_is_br_i      = 1'b1;
        ID_rs_addr_i[0] = 5'd5;
        ID_rs_addr_i[1] = 5'd3;
        EX_rd_addr_i    = 5'd5;
        EX_rd_wren_i    = 1'b1;
        #1;
        check("ex_sel0", fwd_sel_o[0], 2'b01);
        check("ex_data0", rs_data_o[0], EXA);
        check("ex_sel1_none", fwd_sel_o[1], 2'b00);
        check("ex_data1_id", rs_data_o[1], ID1);
        check("ex_stall", stall_o, 1'b0);

        // Same address in MEM too: EX wins.
        MEM_rd_addr_i = 5'd5;
        MEM_rd_wren_i = 1'b1;
        #1;
        check("prio_sel0", fwd_sel_o[0], 2'b01);
        check("prio_data0", rs_data_o[0], EXA);

        // EX write disabled: MEM alu forwarded.
        EX_rd_wren_i = 1'b0;
        #1;
        check("mem_sel0", fwd_sel_o[0], 2'b10);
        check("mem_data0", rs_data_o[0], MEMA);

        // Writes to x0 with source x0, including a pending MEM load.
        ID_rs_addr_i[0] = '0;
        ID_rs_addr_i[1] = '0;
        EX_rd_addr_i    = '0;
        EX_rd_wren_i    = 1'b1;
        MEM_rd_addr_i   = '0;
        MEM_is_ld_i     = 1'b1;
        #1;
        check("x0_sel0", fwd_sel_o[0], 2'b00);
        check("x0_sel1", fwd_sel_o[1], 2'b00);
        check("x0_data0", rs_data_o[0], ID0);
        check("x0_stall", stall_o, 1'b0);
        tick();
        check("x0_state", dut.r_state, ST_IDLE);

        // EX load producer of rs2=7.
        idle_inputs();
        ID_is_br_i      = 1'b1;
        ID_rs_addr_i[1] = 5'd7;
        EX_rd_addr_i    = 5'd7;
        EX_rd_wren_i    = 1'b1;
        EX_is_ld_i      = 1'b1;
        #1;
        check("exld_stall", stall_o, 1'b1);
        tick();
        check("exld_state", dut.r_state, ST_STALL_EXLD);

        // Not a branch: no stall, FSM back to IDLE.
        ID_is_br_i = 1'b0;
        #1;
        check("nobr_stall", stall_o, 1'b0);
        tick();
        check("nobr_state", dut.r_state, ST_IDLE);

        // EX load and MEM load without valid on the same source: EXLD wins.
        ID_is_br_i    = 1'b1;
        MEM_rd_addr_i = 5'd7;
        MEM_rd_wren_i = 1'b1;
        MEM_is_ld_i   = 1'b1;
        #1;
        tick();
        check("both_state", dut.r_state, ST_STALL_EXLD);

        // MEM load of rs2=7, valid arrives after three stalled cycles.
        EX_rd_wren_i = 1'b0;
        EX_is_ld_i   = 1'b0;
        ID_is_br_i   = 1'b0;
        tick();
        check("cnt_clear", dut.r_stall_cnt, 0);
        ID_is_br_i = 1'b1;
        #1;
        check("memld_sel1", fwd_sel_o[1], 2'b11);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("memld_stall_c%0d", c), stall_o, 1'b1);
            tick();
        end
        check("memld_state", dut.r_state, ST_STALL_MEMLD);
        check("memld_no_to", stall_timeout_o, 1'b0);
        MEM_ld_vld_i = 1'b1;
        #1;
        check("memld_vld_stall", stall_o, 1'b0);
        check("memld_vld_data", rs_data_o[1], LDD);
        tick();
        check("memld_vld_state", dut.r_state, ST_IDLE);
        check("memld_vld_cnt", dut.r_stall_cnt, 0);

        // Timeout: hold the MEM load stall; flag sets after 4 stalled cycles.
        MEM_ld_vld_i = 1'b0;
        #1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("to_pending_c%0d", c), stall_timeout_o, 1'b0);
        end
        tick();
        check("to_set", stall_timeout_o, 1'b1);
        tick();
        check("to_saturate_cnt", dut.r_stall_cnt, 4);
        MEM_ld_vld_i = 1'b1;
        tick();
        check("to_sticky", stall_timeout_o, 1'b1);
        check("to_cnt_clear", dut.r_stall_cnt, 0);

        // Reset during a stall abandons it and clears the flag.
        MEM_ld_vld_i = 1'b0;
        tick();
        check("pre_rst_state", dut.r_state, ST_STALL_MEMLD);
        rst_i = 1'b1;
        tick();
        check("rst2_timeout", stall_timeout_o, 1'b0);
        check("rst2_state", dut.r_state, ST_IDLE);
        check("rst2_cnt", dut.r_stall_cnt, 0);
        check("rst2_stall_comb", stall_o, 1'b1);
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_br_fwd_unit
